// File: rtl/counter4_pkg.sv
// Shared encodings and defaults for the 4-bit counter sequencer.
package counter4_pkg;

    localparam int WIDTH_DEF  = 4;
    localparam int PCNT_W_DEF = 8;

    typedef enum logic [1:0] {
        OP_START  = 2'b00,
        OP_PAUSE  = 2'b01,
        OP_RESUME = 2'b10,
        OP_CLEAR  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Whether a command changes anything in the given state; illegal
    // commands are still accepted by the handshake but have no effect.
    function automatic logic op_legal(input state_e st, input op_e op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_START:  ok = (st == ST_IDLE) || (st == ST_PAUSE) || (st == ST_DONE);
            OP_PAUSE:  ok = (st == ST_RUN);
            OP_RESUME: ok = (st == ST_PAUSE);
            OP_CLEAR:  ok = (st != ST_LOAD);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/counter4_dp.sv
// Up-counter datapath: synchronous clear (dominant) and count enable.
module counter4_dp
    import counter4_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Counter register: clear wins over enable, otherwise the value holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (en) begin
            count_r <= count_r + ONE_C;
        end else begin
            count_r <= count_r;
        end
    end

    assign out = count_r;

endmodule

// File: rtl/counter4_ctrl.sv
// Command sequencer that turns the free-running counter into a
// programmable one-shot / periodic timer with tick, done and period count.
module counter4_ctrl
    import counter4_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int PCNT_W = PCNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_limit,
    input  logic              cmd_periodic,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              tick,
    output logic              done,
    output logic [PCNT_W-1:0] periods
);

    localparam logic [PCNT_W-1:0] PONE_C = {{(PCNT_W-1){1'b0}}, 1'b1};

    state_e              state_r;
    logic [WIDTH-1:0]    limit_r;
    logic                periodic_r;
    logic                cmd_ready_r;
    logic                busy_r;
    logic                tick_r;
    logic                done_r;
    logic [PCNT_W-1:0]   periods_r;

    logic                accept_s;
    logic                legal_s;
    logic                terminal_s;
    op_e                 op_s;
    logic                clr_s;
    logic                en_s;
    logic [WIDTH-1:0]    count_s;

    counter4_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_s),
        .en    (en_s),
        .out   (count_s)
    );

    // Handshake and terminal-compare decode.
    always_comb begin
        op_s       = op_e'(cmd_op);
        accept_s   = cmd_valid && cmd_ready_r;
        legal_s    = accept_s && op_legal(state_r, op_s);
        terminal_s = (count_s == limit_r);
    end

    // Datapath controls; an accepted command in RUN pre-empts counting and terminal detection.
    always_comb begin
        clr_s = 1'b0;
        en_s  = 1'b0;
        if (legal_s) begin
            clr_s = (op_s == OP_CLEAR);
        end else begin
            case (state_r)
                ST_LOAD: begin
                    clr_s = 1'b1;
                end
                ST_RUN: begin
                    if (accept_s) begin
                        clr_s = 1'b0;
                    end else if (terminal_s) begin
                        clr_s = periodic_r;
                    end else begin
                        en_s = 1'b1;
                    end
                end
                default: begin
                    clr_s = 1'b0;
                    en_s  = 1'b0;
                end
            endcase
        end
    end

    // Sequencer FSM with registered handshake, status and period outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            limit_r     <= {WIDTH{1'b0}};
            periodic_r  <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            tick_r      <= 1'b0;
            done_r      <= 1'b0;
            periods_r   <= {PCNT_W{1'b0}};
        end else begin
            tick_r <= 1'b0;
            if (legal_s) begin
                case (op_s)
                    OP_START: begin
                        state_r     <= ST_LOAD;
                        limit_r     <= cmd_limit;
                        periodic_r  <= cmd_periodic;
                        done_r      <= 1'b0;
                        busy_r      <= 1'b1;
                        cmd_ready_r <= 1'b0;
                    end
                    OP_PAUSE: begin
                        state_r     <= ST_PAUSE;
                        busy_r      <= 1'b1;
                        cmd_ready_r <= 1'b1;
                    end
                    OP_RESUME: begin
                        state_r     <= ST_RUN;
                        busy_r      <= 1'b1;
                        cmd_ready_r <= 1'b1;
                    end
                    OP_CLEAR: begin
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        done_r      <= 1'b0;
                        periods_r   <= {PCNT_W{1'b0}};
                    end
                    default: begin
                        state_r <= state_r;
                    end
                endcase
            end else begin
                case (state_r)
                    ST_LOAD: begin
                        state_r     <= ST_RUN;
                        busy_r      <= 1'b1;
                        cmd_ready_r <= 1'b1;
                    end
                    ST_RUN: begin
                        if (!accept_s && terminal_s) begin
                            tick_r <= 1'b1;
                            if (periodic_r) begin
                                if (&periods_r) begin
                                    periods_r <= periods_r;
                                end else begin
                                    periods_r <= periods_r + PONE_C;
                                end
                            end else begin
                                done_r      <= 1'b1;
                                state_r     <= ST_DONE;
                                busy_r      <= 1'b0;
                                cmd_ready_r <= 1'b1;
                            end
                        end else begin
                            state_r <= state_r;
                        end
                    end
                    default: begin
                        state_r <= state_r;
                    end
                endcase
            end
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign count     = count_s;
    assign busy      = busy_r;
    assign tick      = tick_r;
    assign done      = done_r;
    assign periods   = periods_r;

endmodule

// File: tb/tb_counter4_ctrl.sv
// Directed self-checking bench for the counter4_ctrl timer sequencer.
module tb_counter4_ctrl;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_limit;
    logic       cmd_periodic;
    logic [3:0] count;
    logic       busy;
    logic       tick;
    logic       done;
    logic [7:0] periods;

    int checks = 0;
    int passed = 0;

    localparam logic [1:0] C_START  = 2'b00;
    localparam logic [1:0] C_PAUSE  = 2'b01;
    localparam logic [1:0] C_RESUME = 2'b10;
    localparam logic [1:0] C_CLEAR  = 2'b11;

    counter4_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_limit    (cmd_limit),
        .cmd_periodic (cmd_periodic),
        .count        (count),
        .busy         (busy),
        .tick         (tick),
        .done         (done),
        .periods      (periods)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [3:0] lim, input logic per);
        cmd_op = op; cmd_limit = lim; cmd_periodic = per; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cyc(2);
        checks++; if (count !== 4'd0) $display("FAIL rst_count got %0d exp 0", count); else passed++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready got %0b exp 1", cmd_ready); else passed++;
        checks++; if ({busy, tick, done} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {busy, tick, done}); else passed++;
        checks++; if (periods !== 8'd0) $display("FAIL rst_periods got %0d exp 0", periods); else passed++;
        reset = 1'b1;
        cyc(1);
        issue(C_START, 4'd5, 1'b1);
        cyc(4);
        checks++; if (count !== 4'd3) $display("FAIL midrun_count got %0d exp 3", count); else passed++;
        #2 reset = 1'b0;
        #1;
        checks++; if (count !== 4'd0) $display("FAIL async_rst_count got %0d exp 0", count); else passed++;
        checks++; if ({busy, tick, done} !== 3'b000) $display("FAIL async_rst_flags got %b exp 000", {busy, tick, done}); else passed++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL async_rst_ready got %0b exp 1", cmd_ready); else passed++;
        @(negedge clk);
        reset = 1'b1;
        cyc(2);
        checks++; if ({cmd_ready, busy, count} !== {1'b1, 1'b0, 4'd0}) $display("FAIL post_rst got ready=%0b busy=%0b count=%0d exp 1 0 0", cmd_ready, busy, count); else passed++;
    endtask

    task automatic test_periodic();
        logic [3:0] exp_c;
        logic       exp_t;
        logic [7:0] exp_p;
        issue(C_START, 4'd3, 1'b1);
        checks++; if ({cmd_ready, busy} !== 2'b01) $display("FAIL per_load got ready=%0b busy=%0b exp 0 1", cmd_ready, busy); else passed++;
        for (int k = 1; k <= 13; k++) begin
            cyc(1);
            exp_c = 4'((k - 1) % 4);
            exp_t = (k >= 5) && ((k - 5) % 4 == 0);
            exp_p = (k < 5) ? 8'd0 : 8'((k - 5) / 4 + 1);
            checks++; if (count !== exp_c) $display("FAIL per_count k=%0d got %0d exp %0d", k, count, exp_c); else passed++;
            checks++; if (tick !== exp_t) $display("FAIL per_tick k=%0d got %0b exp %0b", k, tick, exp_t); else passed++;
            checks++; if (periods !== exp_p) $display("FAIL per_periods k=%0d got %0d exp %0d", k, periods, exp_p); else passed++;
            checks++; if (done !== 1'b0) $display("FAIL per_done k=%0d got %0b exp 0", k, done); else passed++;
        end
        issue(C_CLEAR, 4'd0, 1'b0);
        checks++; if ({periods, count, busy} !== {8'd0, 4'd0, 1'b0}) $display("FAIL per_clear got p=%0d c=%0d b=%0b exp 0 0 0", periods, count, busy); else passed++;
    endtask

    task automatic test_oneshot();
        logic [3:0] exp_c;
        issue(C_START, 4'd9, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            exp_c = (k - 1 > 9) ? 4'd9 : 4'(k - 1);
            checks++; if (count !== exp_c) $display("FAIL os_count k=%0d got %0d exp %0d", k, count, exp_c); else passed++;
            checks++; if (tick !== (k == 11)) $display("FAIL os_tick k=%0d got %0b", k, tick); else passed++;
            checks++; if (done !== (k >= 11)) $display("FAIL os_done k=%0d got %0b", k, done); else passed++;
            checks++; if (busy !== (k <= 10)) $display("FAIL os_busy k=%0d got %0b", k, busy); else passed++;
        end
        issue(C_PAUSE, 4'd0, 1'b0);
        checks++; if ({busy, done, cmd_ready, count} !== {1'b0, 1'b1, 1'b1, 4'd9}) $display("FAIL pause_in_done got b=%0b d=%0b r=%0b c=%0d exp 0 1 1 9", busy, done, cmd_ready, count); else passed++;
        issue(C_START, 4'd2, 1'b0);
        checks++; if ({done, busy, cmd_ready} !== 3'b010) $display("FAIL restart_accept got %b exp 010", {done, busy, cmd_ready}); else passed++;
        cyc(3);
        checks++; if ({count, done} !== {4'd2, 1'b0}) $display("FAIL restart_run got c=%0d d=%0b exp 2 0", count, done); else passed++;
        cyc(1);
        checks++; if ({tick, done, count} !== {1'b1, 1'b1, 4'd2}) $display("FAIL restart_done got t=%0b d=%0b c=%0d exp 1 1 2", tick, done, count); else passed++;
        issue(C_CLEAR, 4'd0, 1'b0);
        checks++; if ({done, count} !== {1'b0, 4'd0}) $display("FAIL os_clear got d=%0b c=%0d exp 0 0", done, count); else passed++;
    endtask

    task automatic test_pause_boundary();
        issue(C_START, 4'd4, 1'b1);
        cyc(5);
        checks++; if (count !== 4'd4) $display("FAIL pb_reach got %0d exp 4", count); else passed++;
        issue(C_PAUSE, 4'd0, 1'b0);
        checks++; if ({count, tick, periods} !== {4'd4, 1'b0, 8'd0}) $display("FAIL pb_pause got c=%0d t=%0b p=%0d exp 4 0 0", count, tick, periods); else passed++;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            checks++; if ({count, tick, busy} !== {4'd4, 1'b0, 1'b1}) $display("FAIL pb_hold k=%0d got c=%0d t=%0b b=%0b exp 4 0 1", k, count, tick, busy); else passed++;
        end
        issue(C_RESUME, 4'd0, 1'b0);
        checks++; if ({count, tick} !== {4'd4, 1'b0}) $display("FAIL pb_resume got c=%0d t=%0b exp 4 0", count, tick); else passed++;
        cyc(1);
        checks++; if ({tick, count, periods} !== {1'b1, 4'd0, 8'd1}) $display("FAIL pb_tick got t=%0b c=%0d p=%0d exp 1 0 1", tick, count, periods); else passed++;
        cyc(1);
        checks++; if ({tick, count} !== {1'b0, 4'd1}) $display("FAIL pb_after got t=%0b c=%0d exp 0 1", tick, count); else passed++;
        issue(C_CLEAR, 4'd0, 1'b0);
    endtask

    task automatic test_handshake();
        cmd_op = C_START; cmd_limit = 4'd2; cmd_periodic = 1'b1; cmd_valid = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL hs_idle_ready got %0b exp 1", cmd_ready); else passed++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (cmd_ready !== (k != 0)) $display("FAIL hs_ready k=%0d got %0b", k, cmd_ready); else passed++;
            checks++; if (busy !== 1'b1) $display("FAIL hs_busy k=%0d got %0b exp 1", k, busy); else passed++;
        end
        cmd_valid = 1'b0;
        issue(C_CLEAR, 4'd0, 1'b0);
        issue(C_RESUME, 4'd0, 1'b0);
        checks++; if ({busy, cmd_ready, count} !== {1'b0, 1'b1, 4'd0}) $display("FAIL resume_in_idle got b=%0b r=%0b c=%0d exp 0 1 0", busy, cmd_ready, count); else passed++;
        cyc(2);
        checks++; if ({busy, count} !== {1'b0, 4'd0}) $display("FAIL idle_stays got b=%0b c=%0d exp 0 0", busy, count); else passed++;
    endtask

    task automatic test_edges();
        logic [3:0] exp_c;
        logic       exp_t;
        // limit 0 periodic
        issue(C_START, 4'd0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            checks++; if (tick !== (k >= 2)) $display("FAIL l0_tick k=%0d got %0b", k, tick); else passed++;
            checks++; if (count !== 4'd0) $display("FAIL l0_count k=%0d got %0d exp 0", k, count); else passed++;
            checks++; if (periods !== ((k >= 2) ? 8'(k - 1) : 8'd0)) $display("FAIL l0_periods k=%0d got %0d", k, periods); else passed++;
        end
        issue(C_CLEAR, 4'd0, 1'b0);
        checks++; if (periods !== 8'd0) $display("FAIL l0_clear got %0d exp 0", periods); else passed++;
        // limit 0 one-shot
        issue(C_START, 4'd0, 1'b0);
        cyc(1);
        checks++; if ({tick, done} !== 2'b00) $display("FAIL l0os_enter got %b exp 00", {tick, done}); else passed++;
        cyc(1);
        checks++; if ({tick, done, busy} !== 3'b110) $display("FAIL l0os_done got %b exp 110", {tick, done, busy}); else passed++;
        issue(C_CLEAR, 4'd0, 1'b0);
        // limit 15 periodic
        issue(C_START, 4'd15, 1'b1);
        for (int k = 1; k <= 34; k++) begin
            cyc(1);
            exp_c = 4'((k - 1) % 16);
            exp_t = (k >= 17) && ((k - 17) % 16 == 0);
            checks++; if (count !== exp_c) $display("FAIL l15_count k=%0d got %0d exp %0d", k, count, exp_c); else passed++;
            checks++; if (tick !== exp_t) $display("FAIL l15_tick k=%0d got %0b exp %0b", k, tick, exp_t); else passed++;
        end
        checks++; if (periods !== 8'd2) $display("FAIL l15_periods got %0d exp 2", periods); else passed++;
        issue(C_CLEAR, 4'd0, 1'b0);
        // saturation after 300 wraps
        issue(C_START, 4'd0, 1'b1);
        cyc(255);
        checks++; if (periods !== 8'd254) $display("FAIL sat_pre got %0d exp 254", periods); else passed++;
        cyc(46);
        checks++; if (periods !== 8'd255) $display("FAIL sat_300 got %0d exp 255", periods); else passed++;
        cyc(5);
        checks++; if ({periods, tick} !== {8'd255, 1'b1}) $display("FAIL sat_hold got p=%0d t=%0b exp 255 1", periods, tick); else passed++;
        issue(C_CLEAR, 4'd0, 1'b0);
        checks++; if ({periods, count, busy} !== {8'd0, 4'd0, 1'b0}) $display("FAIL sat_clear got p=%0d c=%0d b=%0b exp 0 0 0", periods, count, busy); else passed++;
    endtask

    initial begin
        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_limit = 4'd0;
        cmd_periodic = 1'b0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_pause_boundary();
        test_handshake();
        test_edges();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/counter4_ctrl.md
Name: counter4_ctrl

Overview:
Sequencer for the 4-bit up-counter datapath. It accepts start/pause/resume/clear commands over a valid/ready handshake and drives the counter's clear and enable controls. It compares the count against a programmable limit and reports terminal ticks, one-shot completion and a period count. It sits between a host/bus-side requester and the free-running counter, turning the counter into a programmable timer.

Parameters:
WIDTH, 4, counter and limit width in bits
PCNT_W, 8, width of the saturating period counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  2  00 START, 01 PAUSE, 10 RESUME, 11 CLEAR
cmd_limit  input  WIDTH  terminal value; sampled only with an accepted START
cmd_periodic  input  1  1 = auto-reload, 0 = one-shot; sampled only with an accepted START
count  output  WIDTH  current counter value
busy  output  1  high in LOAD, RUN or PAUSE
tick  output  1  one-cycle pulse after the count reaches the limit
done  output  1  level; one-shot finished
periods  output  PCNT_W  completed periods, saturating

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release):
  - state IDLE; count, tick, done and periods = 0; cmd_ready = 1.
  - Reset mid-operation aborts immediately with no tick.
- Handshake: a command is accepted on a rising edge with cmd_valid && cmd_ready.
  - cmd_ready = 0 only in LOAD; otherwise 1.
  - A command that is not legal in the current state is accepted and ignored, with no state change.
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- Command transitions:
  - START, legal in IDLE, PAUSE or DONE: go to LOAD; latch limit_q and periodic_q; clear done.
  - LOAD: count = 0; next state is always RUN (one cycle).
  - PAUSE, legal in RUN: go to PAUSE; count holds.
  - RESUME, legal in PAUSE: go to RUN; count continues from its held value.
  - CLEAR, legal in any state except LOAD: go to IDLE; count, periods and done cleared.
- RUN, per edge, when no command is accepted:
  - count != limit_q: count increments by 1; tick = 0.
  - count == limit_q and periodic: tick = 1; count wraps to 0; periods increments, saturating at all-ones; stay in RUN.
  - count == limit_q and one-shot: tick = 1; done = 1; go to DONE; count holds at limit_q.
- Latency: START accepted at edge E0 gives:
  - LOAD in the cycle after E0;
  - RUN with count=0 after E1;
  - count=L after E(1+L);
  - tick high in the following cycle.
  - The first period is therefore L+1 RUN cycles; subsequent periodic periods are L+1 cycles.
- limit = 0:
  - periodic: tick every RUN cycle, count stays 0.
  - one-shot: tick and done one cycle after entering RUN.
- Simultaneous events: an accepted command has priority over terminal detection in the same cycle. That cycle produces no tick, no wrap and no periods update.
  - PAUSE at count == limit_q: pauses at limit; the terminal event fires on the first RUN edge after RESUME.
- DONE: holds count, done = 1, tick = 0 until START or CLEAR.
- tick is registered and is never high for two consecutive cycles, except in periodic mode with limit = 0.
- Arithmetic: count wraps modulo 2^WIDTH. It can only exceed limit_q by wrapping, which cannot happen because terminal detection precedes the increment.

Decomposition:
- Package counter4_pkg holds:
  - op encodings: OP_START, OP_PAUSE, OP_RESUME, OP_CLEAR;
  - state encodings: ST_IDLE, ST_LOAD, ST_RUN, ST_PAUSE, ST_DONE;
  - the default WIDTH.
- Sub-module counter4_dp holds the counter datapath.
  - Ports: clk, reset, clr, en, out[WIDTH].
  - Async active-low reset; clr has priority over en.
- counter4_ctrl holds the FSM, limit and mode registers, comparator, and the tick/done/periods logic. It drives clr and en of counter4_dp.

Test Plan:
- Reset mid-RUN: periodic, limit 5, at count 3 pull reset low -> all outputs 0 and state IDLE immediately; after release cmd_ready = 1.
- Periodic: START with limit 3, periodic 1 -> count sequence 0,1,2,3,0,...; tick every 4th cycle starting 5 cycles after acceptance; periods 1,2,3 after three wraps; done stays 0.
- One-shot: START with limit 9, periodic 0 -> count reaches 9; one tick; done = 1 in DONE with count held at 9; busy = 0; a second START re-runs and clears done at acceptance.
- Pause/resume at boundary: limit 4, PAUSE accepted when count = 4 -> no tick, count holds 4 for 10 cycles; RESUME -> tick on the first RUN edge; count returns to 0.
- Handshake and illegal commands:
  - cmd_valid held with START -> cmd_ready low for exactly one cycle (LOAD);
  - RESUME in IDLE, PAUSE in DONE -> accepted, no state change.
- Edge values:
  - limit 0 periodic -> tick high every RUN cycle;
  - limit 15 periodic -> 16-cycle period;
  - 300 wraps -> periods saturates at 255;
  - CLEAR -> periods = 0.
